// File: rtl/jkff_counter_pkg.sv
// Shared definitions for the JK flip-flop counter family.
// Holds the {J,K} mode codes and the load saturation helper.
package jkff_counter_pkg;

  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  // A load value outside the count sequence is pulled down to the terminal count
  function automatic logic [15:0] clamp_load(input logic [15:0] value, input int modulus);
    if (int'(value) >= modulus) begin
      return 16'(modulus - 1);
    end
    return value;
  endfunction

endpackage

// File: rtl/jkff_upcount_jk_cell.sv
// Single JK flip-flop cell with synchronous active-high reset.
// Truth table: 00 hold, 01 clear, 10 set, 11 toggle.
module jk_cell
  import jkff_counter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  // JK state update; reset overrides the J/K inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        JK_HOLD:   q <= q;
        JK_RESET:  q <= 1'b0;
        JK_SET:    q <= 1'b1;
        JK_TOGGLE: q <= ~q;
        default:   q <= q;
      endcase
    end
  end

endmodule

// File: rtl/jkff_upcount.sv
// Modulo-MODULUS up counter built from JK cells.
// Each bit gets generated J/K terms: toggle-chain for counting, clear-to-zero
// at terminal count, direct set/clear for parallel load.
// Optional macro JKFF_UPCOUNT_STICKY_OVF_EN adds a sticky overflow output ovf.
module jkff_upcount
  import jkff_counter_pkg::*;
#(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
`ifdef JKFF_UPCOUNT_STICKY_OVF_EN
  ,
  output logic             ovf
`endif
);

  generate
    if (WIDTH < 1 || WIDTH > 16 || MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_params
      $error("jkff_upcount: illegal WIDTH/MODULUS combination");
    end
  endgenerate

  localparam logic [WIDTH-1:0] TERM = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] toggle_mask;
  logic [WIDTH-1:0] load_clamped;
  logic [1:0]       mode;
  logic             carry;
  logic             counted_wrap;

  assign load_clamped = WIDTH'(clamp_load(16'(load_val), MODULUS));
  assign tc           = en && (count == TERM);
  assign counted_wrap = en && !load && (count == TERM);

  // Ripple-style toggle enables: a bit toggles when every lower bit is 1
  always_comb begin
    toggle_mask = '0;
    carry       = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      toggle_mask[i] = carry;
      carry          = carry & count[i];
    end
  end

  // Per-bit J/K generation; at or beyond terminal count set bits are cleared
  // so the next state is 0, which also recovers from unreachable states
  always_comb begin
    j    = '0;
    k    = '0;
    mode = JK_HOLD;
    for (int i = 0; i < WIDTH; i++) begin
      mode = JK_HOLD;
      if (load) begin
        mode = load_clamped[i] ? JK_SET : JK_RESET;
      end else if (en) begin
        if (count >= TERM) begin
          mode = count[i] ? JK_RESET : JK_HOLD;
        end else if (toggle_mask[i]) begin
          mode = JK_TOGGLE;
        end
      end
      {j[i], k[i]} = mode;
    end
  end

  generate
    for (genvar g = 0; g < WIDTH; g++) begin : g_cells
      jk_cell u_cell (
        .clk (clk),
        .rst (rst),
        .j   (j[g]),
        .k   (k[g]),
        .q   (count[g])
      );
    end
  endgenerate

  // One-cycle wrap pulse following a counted terminal-to-zero step
  always_ff @(posedge clk) begin
    if (rst) begin
      wrap <= 1'b0;
    end else begin
      wrap <= counted_wrap;
    end
  end

`ifdef JKFF_UPCOUNT_STICKY_OVF_EN
  // Sticky overflow; reset or load clears it ahead of a same-cycle wrap
  always_ff @(posedge clk) begin
    if (rst || load) begin
      ovf <= 1'b0;
    end else if (counted_wrap) begin
      ovf <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_jkff_upcount.sv
// Directed testbench for jkff_upcount: three instances (modulus 8, 6, 4)
// share one stimulus stream; each row carries hand-computed expectations.
// With JKFF_UPCOUNT_STICKY_OVF_EN defined the ovf output is also checked.
module tb_jkff_upcount;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [2:0] load_val = 3'd0;

  logic [2:0] count8, count6, count4;
  logic       tc8, tc6, tc4;
  logic       wrap8, wrap6, wrap4;
`ifdef JKFF_UPCOUNT_STICKY_OVF_EN
  logic       ovf8, ovf6, ovf4;
`endif

  int checkCount = 0;
  int errorCount = 0;

  typedef struct {
    int rst;  int en;  int load; int val;
    int tc8;  int tc6; int tc4;
    int c8;   int c6;  int c4;
    int w8;   int w6;  int w4;
    int ovf;
  } vec_t;

  // rst en ld val | tc8 tc6 tc4 | c8 c6 c4 | w8 w6 w4 | ovf (modulus-4 unit)
  localparam int NVEC = 31;
  vec_t vecs [NVEC] = '{
    '{1,0,0,0, 0,0,0, 0,0,0, 0,0,0, 0},
    '{0,1,0,0, 0,0,0, 1,1,1, 0,0,0, 0},
    '{0,1,0,0, 0,0,0, 2,2,2, 0,0,0, 0},
    '{0,1,0,0, 0,0,0, 3,3,3, 0,0,0, 0},
    '{0,1,0,0, 0,0,1, 4,4,0, 0,0,1, 1},
    '{0,1,0,0, 0,0,0, 5,5,1, 0,0,0, 1},
    '{0,1,0,0, 0,1,0, 6,0,2, 0,1,0, 1},
    '{0,1,0,0, 0,0,0, 7,1,3, 0,0,0, 1},
    '{0,1,0,0, 1,0,1, 0,2,0, 1,0,1, 1},
    '{0,1,0,0, 0,0,0, 1,3,1, 0,0,0, 1},
    '{0,1,0,0, 0,0,0, 2,4,2, 0,0,0, 1},
    '{0,1,0,0, 0,0,0, 3,5,3, 0,0,0, 1},
    '{0,0,0,0, 0,0,0, 3,5,3, 0,0,0, 1},
    '{0,0,0,0, 0,0,0, 3,5,3, 0,0,0, 1},
    '{0,1,0,0, 0,1,1, 4,0,0, 0,1,1, 1},
    '{0,1,0,0, 0,0,0, 5,1,1, 0,0,0, 1},
    '{0,1,0,0, 0,0,0, 6,2,2, 0,0,0, 1},
    '{0,1,0,0, 0,0,0, 7,3,3, 0,0,0, 1},
    '{0,1,0,0, 1,0,1, 0,4,0, 1,0,1, 1},
    '{0,1,0,0, 0,0,0, 1,5,1, 0,0,0, 1},
    '{0,1,1,3, 0,1,0, 3,3,3, 0,0,0, 0},
    '{0,0,1,7, 0,0,0, 7,5,3, 0,0,0, 0},
    '{0,1,0,0, 1,1,1, 0,0,0, 1,1,1, 1},
    '{0,1,0,0, 0,0,0, 1,1,1, 0,0,0, 1},
    '{0,1,0,0, 0,0,0, 2,2,2, 0,0,0, 1},
    '{0,1,0,0, 0,0,0, 3,3,3, 0,0,0, 1},
    '{0,1,0,0, 0,0,1, 4,4,0, 0,0,1, 1},
    '{0,1,0,0, 0,0,0, 5,5,1, 0,0,0, 1},
    '{1,1,1,4, 0,1,0, 0,0,0, 0,0,0, 0},
    '{0,1,0,0, 0,0,0, 1,1,1, 0,0,0, 0},
    '{0,1,0,0, 0,0,0, 2,2,2, 0,0,0, 0}
  };

  jkff_upcount #(.WIDTH(3), .MODULUS(8)) dut8 (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
    .count(count8), .tc(tc8), .wrap(wrap8)
`ifdef JKFF_UPCOUNT_STICKY_OVF_EN
    , .ovf(ovf8)
`endif
  );

  jkff_upcount #(.WIDTH(3), .MODULUS(6)) dut6 (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
    .count(count6), .tc(tc6), .wrap(wrap6)
`ifdef JKFF_UPCOUNT_STICKY_OVF_EN
    , .ovf(ovf6)
`endif
  );

  jkff_upcount #(.WIDTH(3), .MODULUS(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
    .count(count4), .tc(tc4), .wrap(wrap4)
`ifdef JKFF_UPCOUNT_STICKY_OVF_EN
    , .ovf(ovf4)
`endif
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Count one comparison and report it if the observed value is wrong
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one row of inputs on the falling edge, away from the active edge
  task automatic applyStimulus(input int r, input int e, input int l, input int v);
    @(negedge clk);
    rst      = (r != 0);
    en       = (e != 0);
    load     = (l != 0);
    load_val = 3'(v);
    #1;
  endtask

  // Walk the vector table: combinational tc before the edge, registers after it
  initial begin
    for (int n = 0; n < NVEC; n++) begin
      applyStimulus(vecs[n].rst, vecs[n].en, vecs[n].load, vecs[n].val);
      checkOutput($sformatf("row%0d tc8", n), int'(tc8), vecs[n].tc8);
      checkOutput($sformatf("row%0d tc6", n), int'(tc6), vecs[n].tc6);
      checkOutput($sformatf("row%0d tc4", n), int'(tc4), vecs[n].tc4);
      @(posedge clk);
      #1;
      checkOutput($sformatf("row%0d count8", n), int'(count8), vecs[n].c8);
      checkOutput($sformatf("row%0d count6", n), int'(count6), vecs[n].c6);
      checkOutput($sformatf("row%0d count4", n), int'(count4), vecs[n].c4);
      checkOutput($sformatf("row%0d wrap8", n), int'(wrap8), vecs[n].w8);
      checkOutput($sformatf("row%0d wrap6", n), int'(wrap6), vecs[n].w6);
      checkOutput($sformatf("row%0d wrap4", n), int'(wrap4), vecs[n].w4);
`ifdef JKFF_UPCOUNT_STICKY_OVF_EN
      checkOutput($sformatf("row%0d ovf4", n), int'(ovf4), vecs[n].ovf);
`endif
    end
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
